// File: rtl/i2s_frame_ctrl.sv
// i2s_frame_ctrl: master-mode I2S frame controller placed in front of i2s_core.
//
// Generates the serial bit clock and word select from the system clock. The stream
// starts and stops only on whole-frame boundaries. The din->dout shortcut request is
// retimed to frame starts. A watchdog flags runs of frames in which no received sample
// arrived.
//
// Ports:
//   clk_i          system clock, all logic on the rising edge
//   rst_n_i        asynchronous reset, active low
//   enable_i       level: 1 = run the stream, 0 = stop at the end of the current frame
//   bypass_req_i   requested din->dout shortcut state
//   rx_val_i       received-sample pulse from i2s_core
//   miss_clr_i     pulse: clear missing_o and miss_cnt_o
//   running_o      1 while the controller is not idle
//   i2s_sclk_o     serial bit clock (registered)
//   i2s_lrclk_o    word select, 0 = left slot, 1 = right slot (registered)
//   frame_start_o  1-cycle pulse in the cycle lrclk becomes 0 (start of a left slot)
//   shortcut_o     to i2s_core din_dout_shortcut_i; changes only with frame_start_o
//   missing_o      sticky miss flag
//   miss_cnt_o     saturating count of miss events
module i2s_frame_ctrl #(
  parameter int unsigned SCLK_HALF_DIV = 8,
  parameter int unsigned SLOT_BITS     = 32,
  parameter int unsigned WDOG_FRAMES   = 4,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             enable_i,
  input  logic             bypass_req_i,
  input  logic             rx_val_i,
  input  logic             miss_clr_i,
  output logic             running_o,
  output logic             i2s_sclk_o,
  output logic             i2s_lrclk_o,
  output logic             frame_start_o,
  output logic             shortcut_o,
  output logic             missing_o,
  output logic [CNT_W-1:0] miss_cnt_o
);

  localparam int unsigned DivW = (SCLK_HALF_DIV > 1) ? $clog2(SCLK_HALF_DIV) : 1;
  localparam int unsigned BitW = (SLOT_BITS > 1) ? $clog2(SLOT_BITS) : 1;
  localparam int unsigned FrW  = $clog2(WDOG_FRAMES + 1);

  localparam logic [DivW-1:0] DivLast = DivW'(SCLK_HALF_DIV - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(SLOT_BITS - 1);
  localparam logic [FrW-1:0]  FrLast  = FrW'(WDOG_FRAMES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StStop
  } state_e;

  state_e           state_q, state_d;
  logic [DivW-1:0]  div_q, div_d;
  logic [BitW-1:0]  bit_q, bit_d;
  logic             sclk_q, sclk_d;
  logic             lrclk_q, lrclk_d;
  logic             fs_q, fs_d;
  logic             running_q, running_d;
  logic             sc_q, sc_d;
  logic [FrW-1:0]   fr_q, fr_d;
  logic             miss_q, miss_d;
  logic [CNT_W-1:0] mcnt_q, mcnt_d;

  logic tick;
  logic sclk_fall;
  logic slot_end;
  logic frame_end;
  logic miss_evt;

  // Clock timing decode.
  always_comb begin
    tick      = (div_q == DivLast);
    sclk_fall = tick && sclk_q;
    slot_end  = sclk_fall && (bit_q == BitLast);
    frame_end = slot_end && lrclk_q;
  end

  // Frame FSM and clock generation.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    sclk_d  = sclk_q;
    lrclk_d = lrclk_q;
    fs_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        div_d   = '0;
        bit_d   = '0;
        sclk_d  = 1'b0;
        lrclk_d = 1'b0;
        if (enable_i) begin
          state_d = StRun;
          fs_d    = 1'b1;
        end
      end

      StRun, StStop: begin
        if (tick) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
        end else begin
          div_d = div_q + 1'b1;
        end
        if (sclk_fall) begin
          bit_d = (bit_q == BitLast) ? '0 : bit_q + 1'b1;
        end
        if (slot_end) begin
          lrclk_d = ~lrclk_q;
        end

        if (frame_end && !enable_i) begin
          // The frame is complete: drop straight to idle without a start pulse.
          state_d = StIdle;
          div_d   = '0;
          bit_d   = '0;
          sclk_d  = 1'b0;
          lrclk_d = 1'b0;
        end else begin
          // Re-enabling while stopping keeps the running stream and its counters.
          state_d = enable_i ? StRun : StStop;
          fs_d    = frame_end;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Shortcut retiming and running flag.
  always_comb begin
    sc_d      = fs_d ? bypass_req_i : sc_q;
    running_d = (state_d != StIdle);
  end

  // Watchdog: counts visible frame-start pulses, cleared by any received sample.
  always_comb begin
    fr_d     = fr_q;
    miss_evt = 1'b0;
    if (state_q == StIdle) begin
      fr_d = '0;
    end else if (rx_val_i) begin
      fr_d = '0;
    end else if (fs_q) begin
      if (fr_q == FrLast) begin
        fr_d     = '0;
        miss_evt = 1'b1;
      end else begin
        fr_d = fr_q + 1'b1;
      end
    end
  end

  // Miss flag and counter; a same-cycle miss event beats the clear.
  always_comb begin
    miss_d = miss_q;
    mcnt_d = mcnt_q;
    if (miss_evt) begin
      miss_d = 1'b1;
      if (miss_clr_i) begin
        mcnt_d = CNT_W'(1);
      end else if (mcnt_q != '1) begin
        mcnt_d = mcnt_q + 1'b1;
      end
    end else if (miss_clr_i) begin
      miss_d = 1'b0;
      mcnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= StIdle;
      div_q     <= '0;
      bit_q     <= '0;
      sclk_q    <= 1'b0;
      lrclk_q   <= 1'b0;
      fs_q      <= 1'b0;
      running_q <= 1'b0;
      sc_q      <= 1'b0;
      fr_q      <= '0;
      miss_q    <= 1'b0;
      mcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      sclk_q    <= sclk_d;
      lrclk_q   <= lrclk_d;
      fs_q      <= fs_d;
      running_q <= running_d;
      sc_q      <= sc_d;
      fr_q      <= fr_d;
      miss_q    <= miss_d;
      mcnt_q    <= mcnt_d;
    end
  end

  always_comb begin
    running_o     = running_q;
    i2s_sclk_o    = sclk_q;
    i2s_lrclk_o   = lrclk_q;
    frame_start_o = fs_q;
    shortcut_o    = sc_q;
    missing_o     = miss_q;
    miss_cnt_o    = mcnt_q;
  end

endmodule
